// File: rtl/systolic_array_4x4_pkg.sv
// rtl/systolic_array_4x4_pkg.sv - shared constants for the 4x4 dual systolic multiplier
package systolic_array_4x4_pkg;
    localparam int WIDTH = 8;
    localparam int N = 4;
    localparam int ACC_W = 2 * WIDTH;

    typedef logic [3:0] step_t;

    localparam step_t LAST_STEP = 4'd9;
    localparam step_t DONE_STEP = 4'd10;
endpackage

// File: rtl/systolic_array_4x4_sa_pe.sv
// rtl/systolic_array_4x4_sa_pe.sv - one processing element: a/b/c pass-through and two signed MACs
module sa_pe
    import systolic_array_4x4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out,
    output logic [ACC_W-1:0] acc1,
    output logic [ACC_W-1:0] acc2
);
    logic signed [ACC_W-1:0] a_sx;
    logic signed [ACC_W-1:0] b_sx;
    logic signed [ACC_W-1:0] c_sx;
    logic [ACC_W-1:0] prod_ab;
    logic [ACC_W-1:0] prod_ac;

    // Operands are sign-extended first so the 2W-bit product is the exact signed value.
    assign a_sx = {{WIDTH{a_in[WIDTH-1]}}, a_in};
    assign b_sx = {{WIDTH{b_in[WIDTH-1]}}, b_in};
    assign c_sx = {{WIDTH{c_in[WIDTH-1]}}, c_in};
    assign prod_ab = a_sx * b_sx;
    assign prod_ac = a_sx * c_sx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            c_out <= '0;
            acc1  <= '0;
            acc2  <= '0;
        end else if (clear) begin
            a_out <= '0;
            b_out <= '0;
            c_out <= '0;
            acc1  <= '0;
            acc2  <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            c_out <= c_in;
            acc1  <= acc1 + prod_ab;
            acc2  <= acc2 + prod_ac;
        end
    end
endmodule

// File: rtl/systolic_array_4x4.sv
// rtl/systolic_array_4x4.sv - output-stationary 4x4 array computing R1=A*B and R2=A*C
module systolic_array_4x4
    import systolic_array_4x4_pkg::*;
(
    input  logic [WIDTH-1:0] a00, a01, a02, a03, a10, a11, a12, a13,
    input  logic [WIDTH-1:0] a20, a21, a22, a23, a30, a31, a32, a33,
    input  logic [WIDTH-1:0] b00, b10, b20, b30, b01, b11, b21, b31,
    input  logic [WIDTH-1:0] b02, b12, b22, b32, b03, b13, b23, b33,
    input  logic [WIDTH-1:0] c00, c10, c20, c30, c01, c11, c21, c31,
    input  logic [WIDTH-1:0] c02, c12, c22, c32, c03, c13, c23, c33,
    input  logic             clk,
    input  logic             _reset,
    input  logic             _flush_acc,
    output logic [ACC_W-1:0] r1_00, r1_01, r1_02, r1_03, r1_10, r1_11, r1_12, r1_13,
    output logic [ACC_W-1:0] r1_20, r1_21, r1_22, r1_23, r1_30, r1_31, r1_32, r1_33,
    output logic [ACC_W-1:0] r2_00, r2_01, r2_02, r2_03, r2_10, r2_11, r2_12, r2_13,
    output logic [ACC_W-1:0] r2_20, r2_21, r2_22, r2_23, r2_30, r2_31, r2_32, r2_33,
    output logic             done
);
    logic [WIDTH-1:0] a_m [N][N];
    logic [WIDTH-1:0] b_m [N][N];
    logic [WIDTH-1:0] c_m [N][N];
    logic [ACC_W-1:0] r1_m [N][N];
    logic [ACC_W-1:0] r2_m [N][N];

    logic [WIDTH-1:0] a_left [N];
    logic [WIDTH-1:0] b_top  [N];
    logic [WIDTH-1:0] c_top  [N];
    logic [WIDTH-1:0] a_bus [N][N+1];
    logic [WIDTH-1:0] b_bus [N+1][N];
    logic [WIDTH-1:0] c_bus [N+1][N];

    step_t step;
    logic  clear;
    logic  en;

    assign a_m[0][0] = a00; assign a_m[0][1] = a01; assign a_m[0][2] = a02; assign a_m[0][3] = a03;
    assign a_m[1][0] = a10; assign a_m[1][1] = a11; assign a_m[1][2] = a12; assign a_m[1][3] = a13;
    assign a_m[2][0] = a20; assign a_m[2][1] = a21; assign a_m[2][2] = a22; assign a_m[2][3] = a23;
    assign a_m[3][0] = a30; assign a_m[3][1] = a31; assign a_m[3][2] = a32; assign a_m[3][3] = a33;
    assign b_m[0][0] = b00; assign b_m[0][1] = b01; assign b_m[0][2] = b02; assign b_m[0][3] = b03;
    assign b_m[1][0] = b10; assign b_m[1][1] = b11; assign b_m[1][2] = b12; assign b_m[1][3] = b13;
    assign b_m[2][0] = b20; assign b_m[2][1] = b21; assign b_m[2][2] = b22; assign b_m[2][3] = b23;
    assign b_m[3][0] = b30; assign b_m[3][1] = b31; assign b_m[3][2] = b32; assign b_m[3][3] = b33;
    assign c_m[0][0] = c00; assign c_m[0][1] = c01; assign c_m[0][2] = c02; assign c_m[0][3] = c03;
    assign c_m[1][0] = c10; assign c_m[1][1] = c11; assign c_m[1][2] = c12; assign c_m[1][3] = c13;
    assign c_m[2][0] = c20; assign c_m[2][1] = c21; assign c_m[2][2] = c22; assign c_m[2][3] = c23;
    assign c_m[3][0] = c30; assign c_m[3][1] = c31; assign c_m[3][2] = c32; assign c_m[3][3] = c33;

    assign clear = ~_flush_acc;
    assign en    = (step <= LAST_STEP);

    // Row i / column j is skewed by its index: term k enters at step index+k, zero otherwise.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_left[i] = '0;
            b_top[i]  = '0;
            c_top[i]  = '0;
            for (int k = 0; k < N; k++) begin
                if (step == step_t'(i + k)) begin
                    a_left[i] = a_m[i][k];
                    b_top[i]  = b_m[k][i];
                    c_top[i]  = c_m[k][i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge _reset) begin
        if (_reset) begin
            step <= '0;
            done <= 1'b0;
        end else if (clear) begin
            step <= '0;
            done <= 1'b0;
        end else begin
            if (step != DONE_STEP)
                step <= step + 4'd1;
            if (step == DONE_STEP)
                done <= 1'b1;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_edge
            assign a_bus[gi][0] = a_left[gi];
            assign b_bus[0][gi] = b_top[gi];
            assign c_bus[0][gi] = c_top[gi];
        end
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                sa_pe u_pe (
                    .clk   (clk),
                    .rst   (_reset),
                    .clear (clear),
                    .en    (en),
                    .a_in  (a_bus[gi][gj]),
                    .b_in  (b_bus[gi][gj]),
                    .c_in  (c_bus[gi][gj]),
                    .a_out (a_bus[gi][gj+1]),
                    .b_out (b_bus[gi+1][gj]),
                    .c_out (c_bus[gi+1][gj]),
                    .acc1  (r1_m[gi][gj]),
                    .acc2  (r2_m[gi][gj])
                );
            end
        end
    endgenerate

    assign r1_00 = r1_m[0][0]; assign r1_01 = r1_m[0][1]; assign r1_02 = r1_m[0][2]; assign r1_03 = r1_m[0][3];
    assign r1_10 = r1_m[1][0]; assign r1_11 = r1_m[1][1]; assign r1_12 = r1_m[1][2]; assign r1_13 = r1_m[1][3];
    assign r1_20 = r1_m[2][0]; assign r1_21 = r1_m[2][1]; assign r1_22 = r1_m[2][2]; assign r1_23 = r1_m[2][3];
    assign r1_30 = r1_m[3][0]; assign r1_31 = r1_m[3][1]; assign r1_32 = r1_m[3][2]; assign r1_33 = r1_m[3][3];
    assign r2_00 = r2_m[0][0]; assign r2_01 = r2_m[0][1]; assign r2_02 = r2_m[0][2]; assign r2_03 = r2_m[0][3];
    assign r2_10 = r2_m[1][0]; assign r2_11 = r2_m[1][1]; assign r2_12 = r2_m[1][2]; assign r2_13 = r2_m[1][3];
    assign r2_20 = r2_m[2][0]; assign r2_21 = r2_m[2][1]; assign r2_22 = r2_m[2][2]; assign r2_23 = r2_m[2][3];
    assign r2_30 = r2_m[3][0]; assign r2_31 = r2_m[3][1]; assign r2_32 = r2_m[3][2]; assign r2_33 = r2_m[3][3];
endmodule

// File: tb/tb_systolic_array_4x4.sv
// tb/tb_systolic_array_4x4.sv - self-checking bench for systolic_array_4x4
module tb_systolic_array_4x4;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic flush_n;
    logic [7:0] ma [4][4];
    logic [7:0] mb [4][4];
    logic [7:0] mc [4][4];
    logic [15:0] r1 [4][4];
    logic [15:0] r2 [4][4];
    logic [15:0] e1 [4][4];
    logic [15:0] e2 [4][4];
    logic done;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [7:0]  a, b, c;
        logic [15:0] r1, r2;
    } vec_t;
    vec_t vecs [4];

    systolic_array_4x4 dut (
        .a00(ma[0][0]), .a01(ma[0][1]), .a02(ma[0][2]), .a03(ma[0][3]),
        .a10(ma[1][0]), .a11(ma[1][1]), .a12(ma[1][2]), .a13(ma[1][3]),
        .a20(ma[2][0]), .a21(ma[2][1]), .a22(ma[2][2]), .a23(ma[2][3]),
        .a30(ma[3][0]), .a31(ma[3][1]), .a32(ma[3][2]), .a33(ma[3][3]),
        .b00(mb[0][0]), .b10(mb[1][0]), .b20(mb[2][0]), .b30(mb[3][0]),
        .b01(mb[0][1]), .b11(mb[1][1]), .b21(mb[2][1]), .b31(mb[3][1]),
        .b02(mb[0][2]), .b12(mb[1][2]), .b22(mb[2][2]), .b32(mb[3][2]),
        .b03(mb[0][3]), .b13(mb[1][3]), .b23(mb[2][3]), .b33(mb[3][3]),
        .c00(mc[0][0]), .c10(mc[1][0]), .c20(mc[2][0]), .c30(mc[3][0]),
        .c01(mc[0][1]), .c11(mc[1][1]), .c21(mc[2][1]), .c31(mc[3][1]),
        .c02(mc[0][2]), .c12(mc[1][2]), .c22(mc[2][2]), .c32(mc[3][2]),
        .c03(mc[0][3]), .c13(mc[1][3]), .c23(mc[2][3]), .c33(mc[3][3]),
        .clk(clk), ._reset(rst), ._flush_acc(flush_n),
        .r1_00(r1[0][0]), .r1_01(r1[0][1]), .r1_02(r1[0][2]), .r1_03(r1[0][3]),
        .r1_10(r1[1][0]), .r1_11(r1[1][1]), .r1_12(r1[1][2]), .r1_13(r1[1][3]),
        .r1_20(r1[2][0]), .r1_21(r1[2][1]), .r1_22(r1[2][2]), .r1_23(r1[2][3]),
        .r1_30(r1[3][0]), .r1_31(r1[3][1]), .r1_32(r1[3][2]), .r1_33(r1[3][3]),
        .r2_00(r2[0][0]), .r2_01(r2[0][1]), .r2_02(r2[0][2]), .r2_03(r2[0][3]),
        .r2_10(r2[1][0]), .r2_11(r2[1][1]), .r2_12(r2[1][2]), .r2_13(r2[1][3]),
        .r2_20(r2[2][0]), .r2_21(r2[2][1]), .r2_22(r2[2][2]), .r2_23(r2[2][3]),
        .r2_30(r2[3][0]), .r2_31(r2[3][1]), .r2_32(r2[3][2]), .r2_33(r2[3][3]),
        .done(done)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain matrix products in integer arithmetic, reduced mod 2^16.
    task automatic model();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s1 = 0;
                int s2 = 0;
                for (int k = 0; k < 4; k++) begin
                    int av = $signed(ma[i][k]);
                    int bv = $signed(mb[k][j]);
                    int cv = $signed(mc[k][j]);
                    s1 += av * bv;
                    s2 += av * cv;
                end
                e1[i][j] = s1[15:0];
                e2[i][j] = s2[15:0];
            end
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = a;
                mb[i][j] = b;
                mc[i][j] = c;
            end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                check($sformatf("%s r1[%0d][%0d]", tag, i, j), r1[i][j], 16'h0);
                check($sformatf("%s r2[%0d][%0d]", tag, i, j), r2[i][j], 16'h0);
            end
        check($sformatf("%s done", tag), {15'h0, done}, 16'h0);
    endtask

    task automatic check_model(input string tag);
        model();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                check($sformatf("%s r1[%0d][%0d]", tag, i, j), r1[i][j], e1[i][j]);
                check($sformatf("%s r2[%0d][%0d]", tag, i, j), r2[i][j], e2[i][j]);
            end
    endtask

    task automatic do_flush(input string tag);
        @(negedge clk) flush_n = 1'b0;
        @(posedge clk);
        #1 check_zero({tag, " flush"});
        @(negedge clk) flush_n = 1'b1;
    endtask

    // Expects the array to be cleared and released just before the next rising edge.
    task automatic run_pass(input string tag);
        logic early = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1 if (done) early = 1'b1;
        end
        check({tag, " done_early"}, {15'h0, early}, 16'h0);
        @(posedge clk);
        #1 check({tag, " done_edge11"}, {15'h0, done}, 16'h1);
        check_model(tag);
    endtask

    initial begin
        vecs[0] = '{"pos_neg",  8'h02, 8'h03, 8'hFF, 16'h0018, 16'hFFF8};
        vecs[1] = '{"wrap_min", 8'h80, 8'h80, 8'h7F, 16'h0000, 16'h0200};
        vecs[2] = '{"wrap_max", 8'h7F, 8'h7F, 8'h80, 16'hFC04, 16'h0200};
        vecs[3] = '{"zero_a",   8'h00, 8'h55, 8'h12, 16'h0000, 16'h0000};

        // Scenario 1: identity A under reset, then one full pass.
        rst = 1'b1;
        flush_n = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 8'd1 : 8'd0;
                mb[i][j] = 8'(4 * i + j);
                mc[i][j] = 8'd1;
            end
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst = 1'b0;
        run_pass("ident");
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                check($sformatf("ident_b r1[%0d][%0d]", i, j), r1[i][j], 16'(4 * i + j));
                check($sformatf("ident_one r2[%0d][%0d]", i, j), r2[i][j], 16'h1);
            end

        // Uniform-operand table.
        for (int v = 0; v < 4; v++) begin
            fill(vecs[v].a, vecs[v].b, vecs[v].c);
            do_flush(vecs[v].name);
            run_pass(vecs[v].name);
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    check($sformatf("%s tbl r1[%0d][%0d]", vecs[v].name, i, j), r1[i][j], vecs[v].r1);
                    check($sformatf("%s tbl r2[%0d][%0d]", vecs[v].name, i, j), r2[i][j], vecs[v].r2);
                end
        end

        // Scenario 4: flush after done, recompute, results hold while done stays high.
        fill(8'h02, 8'h03, 8'hFF);
        do_flush("refl_a");
        run_pass("refl_a");
        do_flush("refl_b");
        run_pass("refl_b");
        repeat (5) @(posedge clk);
        #1 check("hold done", {15'h0, done}, 16'h1);
        check("hold r1[3][3]", r1[3][3], 16'h0018);
        check("hold r2[0][0]", r2[0][0], 16'hFFF8);

        // Scenario 5: asynchronous reset between edges mid-pass.
        do_flush("async");
        repeat (5) @(posedge clk);
        #1 check("async partial r1[0][0]", r1[0][0], 16'h0018);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk) rst = 1'b0;
        run_pass("after_rst");

        // Scenario 6: random operands with a flush between passes.
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ma[i][j] = 8'($urandom);
                    mb[i][j] = 8'($urandom);
                    mc[i][j] = 8'($urandom);
                end
            do_flush($sformatf("rnd%0d", p));
            run_pass($sformatf("rnd%0d", p));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
